// File: rtl/mem1_pkg.sv
// Shared types, aluop codes and store-lane helpers for the mem1 memory-access stage.
package mem1_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic [7:0] EXE_LD_B_OP  = 8'h20;
    localparam logic [7:0] EXE_LD_BU_OP = 8'h21;
    localparam logic [7:0] EXE_LD_H_OP  = 8'h22;
    localparam logic [7:0] EXE_LD_HU_OP = 8'h23;
    localparam logic [7:0] EXE_LD_W_OP  = 8'h24;
    localparam logic [7:0] EXE_ST_B_OP  = 8'h28;
    localparam logic [7:0] EXE_ST_H_OP  = 8'h29;
    localparam logic [7:0] EXE_ST_W_OP  = 8'h2A;

    typedef struct packed {
        logic                  valid;
        logic                  excp;
        logic [5:0]            excp_num;
        logic [ADDR_WIDTH-1:0] pc;
    } instr_info_t;

    typedef struct packed {
        instr_info_t           instr_info;
        logic [7:0]            aluop;
        logic                  mem_load;
        logic                  mem_store;
        logic [ADDR_WIDTH-1:0] mem_addr;
        logic [DATA_WIDTH-1:0] reg2;
        logic                  data_uncache_en;
        logic                  wreg;
        logic [4:0]            waddr;
        logic [DATA_WIDTH-1:0] wdata;
    } ex_mem_struct;

    typedef struct packed {
        instr_info_t           instr_info;
        logic                  wreg;
        logic [4:0]            waddr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_wb_struct;

    typedef struct packed {
        logic                  wreg;
        logic                  data_valid;
        logic [4:0]            waddr;
        logic [DATA_WIDTH-1:0] wdata;
    } data_forward_t;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            wstrb;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  uncached;
    } dcache_req_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RESP = 2'd1,
        S_HOLD      = 2'd2,
        S_DRAIN     = 2'd3
    } mem1_state_t;

    function automatic logic [3:0] store_strb(input logic [7:0] op, input logic [1:0] lo);
        if (op == EXE_ST_B_OP)      return 4'b0001 << lo;
        else if (op == EXE_ST_H_OP) return lo[1] ? 4'b1100 : 4'b0011;
        else                        return 4'hF;
    endfunction

    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] r2);
        if (op == EXE_ST_B_OP)      return {4{r2[7:0]}};
        else if (op == EXE_ST_H_OP) return {2{r2[15:0]}};
        else                        return r2;
    endfunction

endpackage

// File: rtl/mem1_load_align.sv
// Load lane select and sign/zero extension of the raw aligned DCache word.
module load_align (
    input  logic [1:0]  addr_lo_i,
    input  logic        byte_i,
    input  logic        half_i,
    input  logic        signed_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo_i)
            2'd0:    lane_b = raw_i[7:0];
            2'd1:    lane_b = raw_i[15:8];
            2'd2:    lane_b = raw_i[23:16];
            default: lane_b = raw_i[31:24];
        endcase
        lane_h = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
        if (byte_i)
            data_o = {{24{signed_i & lane_b[7]}}, lane_b};
        else if (half_i)
            data_o = {{16{signed_i & lane_h[15]}}, lane_h};
        else
            data_o = raw_i;
    end
endmodule

// File: rtl/mem1.sv
// Memory-access stage: one DCache request per instruction, stalls until done, registers mem_wb.
// MEM1_LOAD_FORWARD_EN: when defined, load results are forwarded to dispatch before writeback.
module mem1
    import mem1_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          clear,
    input  logic          advance,
    output logic          advance_ready,
    input  ex_mem_struct  ex_i,
    output logic          dcache_req_valid_o,
    input  logic          dcache_req_ready_i,
    output logic          dcache_req_we_o,
    output logic [31:0]   dcache_req_addr_o,
    output logic [3:0]    dcache_req_wstrb_o,
    output logic [31:0]   dcache_req_wdata_o,
    output logic          dcache_req_uncached_o,
    input  logic          dcache_resp_valid_i,
    input  logic [31:0]   dcache_resp_data_i,
    output data_forward_t data_forward_o,
    output mem_wb_struct  mem_o_buffer
);
    mem1_state_t   state_q, state_d;
    logic [31:0]   res_q, res_d;
    mem_wb_struct  mem_buf_q, mem_buf_d;
    dcache_req_t   req;
    data_forward_t fwd;

    logic        memop, is_load, is_store, resp_ok, req_valid;
    logic [31:0] ld_ext, load_wdata;
    logic        ld_byte, ld_half, ld_signed;

    assign memop    = ex_i.instr_info.valid & ~ex_i.instr_info.excp & (ex_i.mem_load | ex_i.mem_store);
    assign is_load  = memop & ex_i.mem_load;
    assign is_store = memop & ex_i.mem_store & ~ex_i.mem_load;
    assign resp_ok  = (state_q == S_WAIT_RESP) & dcache_resp_valid_i & ~flush;

    assign ld_byte   = (ex_i.aluop == EXE_LD_B_OP) | (ex_i.aluop == EXE_LD_BU_OP);
    assign ld_half   = (ex_i.aluop == EXE_LD_H_OP) | (ex_i.aluop == EXE_LD_HU_OP);
    assign ld_signed = (ex_i.aluop != EXE_LD_BU_OP) & (ex_i.aluop != EXE_LD_HU_OP);

    load_align u_load_align (
        .addr_lo_i (ex_i.mem_addr[1:0]),
        .byte_i    (ld_byte),
        .half_i    (ld_half),
        .signed_i  (ld_signed),
        .raw_i     (dcache_resp_data_i),
        .data_o    (ld_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            res_q     <= '0;
            mem_buf_q <= '0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            mem_buf_q <= mem_buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (memop && !flush && dcache_req_ready_i) begin
                    if (is_load)      state_d = S_WAIT_RESP;
                    else if (!advance) state_d = S_HOLD;
                end
            end
            S_WAIT_RESP: begin
                if (flush)                    state_d = dcache_resp_valid_i ? S_IDLE : S_DRAIN;
                else if (dcache_resp_valid_i) state_d = advance ? S_IDLE : S_HOLD;
            end
            S_HOLD:  if (advance || flush)   state_d = S_IDLE;
            S_DRAIN: if (dcache_resp_valid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_valid     = 1'b0;
        advance_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_valid     = memop & ~flush;
                advance_ready = ~memop | (is_store & ~flush & dcache_req_ready_i);
            end
            S_WAIT_RESP: advance_ready = resp_ok;
            S_HOLD:      advance_ready = 1'b1;
            default:     advance_ready = 1'b0;
        endcase
    end

    // HOLD presents the latched result; the response cycle uses the live word.
    assign res_d      = resp_ok ? ld_ext : res_q;
    assign load_wdata = (state_q == S_HOLD) ? res_q : ld_ext;

    always_comb begin
        req.valid    = req_valid & rst;
        req.we       = is_store;
        req.addr     = ex_i.mem_addr;
        req.wstrb    = is_store ? store_strb(ex_i.aluop, ex_i.mem_addr[1:0]) : 4'h0;
        req.wdata    = store_data(ex_i.aluop, ex_i.reg2);
        req.uncached = ex_i.data_uncache_en;
    end

    assign dcache_req_valid_o    = req.valid;
    assign dcache_req_we_o       = req.we;
    assign dcache_req_addr_o     = req.addr;
    assign dcache_req_wstrb_o    = req.wstrb;
    assign dcache_req_wdata_o    = req.wdata;
    assign dcache_req_uncached_o = req.uncached;

    always_comb begin
        fwd.wreg       = ex_i.instr_info.valid & ex_i.wreg;
        fwd.waddr      = ex_i.waddr;
        fwd.data_valid = 1'b1;
        fwd.wdata      = ex_i.wdata;
        if (is_load) begin
`ifdef MEM1_LOAD_FORWARD_EN
            fwd.data_valid = resp_ok | (state_q == S_HOLD);
            fwd.wdata      = load_wdata;
`else
            fwd.data_valid = 1'b0;
`endif
        end
        if (!rst) fwd = '0;
    end

    assign data_forward_o = fwd;

    always_comb begin
        mem_buf_d = mem_buf_q;
        if (flush || clear) begin
            mem_buf_d = '0;
        end else if (advance) begin
            mem_buf_d.instr_info = ex_i.instr_info;
            mem_buf_d.wreg       = ex_i.wreg;
            mem_buf_d.waddr      = ex_i.waddr;
            mem_buf_d.wdata      = is_load ? load_wdata : ex_i.wdata;
        end
    end

    assign mem_o_buffer = mem_buf_q;
endmodule

// File: tb/tb_mem1.sv
// Directed bench for mem1: stores, aligned loads, stalls, flush/drain, exceptions and reset.
module tb_mem1;
    import mem1_pkg::*;

    logic          clk = 1'b0;
    logic          rst, flush, clear, advance, advance_ready;
    ex_mem_struct  ex;
    logic          req_valid, req_ready, req_we, req_uncached;
    logic [31:0]   req_addr, req_wdata;
    logic [3:0]    req_wstrb;
    logic          resp_valid;
    logic [31:0]   resp_data;
    data_forward_t fwd;
    mem_wb_struct  wb;

    int n_chk  = 0;
    int n_pass = 0;

    mem1 dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush                 (flush),
        .clear                 (clear),
        .advance               (advance),
        .advance_ready         (advance_ready),
        .ex_i                  (ex),
        .dcache_req_valid_o    (req_valid),
        .dcache_req_ready_i    (req_ready),
        .dcache_req_we_o       (req_we),
        .dcache_req_addr_o     (req_addr),
        .dcache_req_wstrb_o    (req_wstrb),
        .dcache_req_wdata_o    (req_wdata),
        .dcache_req_uncached_o (req_uncached),
        .dcache_resp_valid_i   (resp_valid),
        .dcache_resp_data_i    (resp_data),
        .data_forward_o        (fwd),
        .mem_o_buffer          (wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ex(input logic [7:0] op, input logic ld, input logic st,
                          input logic [31:0] addr, input logic [31:0] r2, input logic wreg,
                          input logic [4:0] waddr, input logic [31:0] wdata, input logic excp);
        ex = '0;
        ex.instr_info.valid = 1'b1;
        ex.instr_info.excp  = excp;
        ex.instr_info.pc    = 32'h1C00_0000;
        ex.aluop     = op;
        ex.mem_load  = ld;
        ex.mem_store = st;
        ex.mem_addr  = addr;
        ex.reg2      = r2;
        ex.wreg      = wreg;
        ex.waddr     = waddr;
        ex.wdata     = wdata;
    endtask

    // Load with ready high and the response in the following cycle, advancing on it.
    task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] raw, input logic [31:0] exp);
        set_ex(op, 1'b1, 1'b0, addr, 32'h0, 1'b1, 5'd7, 32'h0, 1'b0);
        req_ready = 1'b1;
        #1;
        chk({tag, "_req"}, 32'({req_valid, req_we, req_wstrb}), 32'b100000);
        chk({tag, "_stall"}, 32'(advance_ready), 32'd0);
        cyc;
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = raw;
        #1;
        chk({tag, "_resp_rdy"}, 32'({advance_ready, req_valid}), 32'b10);
`ifdef MEM1_LOAD_FORWARD_EN
        chk({tag, "_fwd"}, fwd.wdata, exp);
        chk({tag, "_fwd_v"}, 32'(fwd.data_valid), 32'd1);
`else
        chk({tag, "_fwd_v"}, 32'(fwd.data_valid), 32'd0);
`endif
        advance = 1'b1;
        cyc;
        advance    = 1'b0;
        resp_valid = 1'b0;
        #1;
        chk({tag, "_wb"}, wb.wdata, exp);
        chk({tag, "_wb_addr"}, 32'(wb.waddr), 32'd7);
    endtask

    always @(posedge clk)
        if (rst && advance && !advance_ready)
            chk("adv_legal", 32'(advance_ready), 32'd1);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; flush = 1'b0; clear = 1'b0; advance = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        set_ex(EXE_LD_W_OP, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 1'b1, 5'd3, 32'h0, 1'b0);
        @(negedge clk);
        cyc;
        #1;
        chk("rst_buf", 32'(|wb), 32'd0);
        chk("rst_req", 32'(req_valid), 32'd0);
        chk("rst_fwd", 32'(|fwd), 32'd0);

        rst = 1'b1;
        set_ex(EXE_ST_W_OP, 1'b0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0);
        req_ready = 1'b1;
        #1;
        chk("sw_req", 32'({req_valid, req_we, req_wstrb}), 32'b11_1111);
        chk("sw_addr", req_addr, 32'h1000_0004);
        chk("sw_wdata", req_wdata, 32'hDEAD_BEEF);
        chk("sw_rdy", 32'(advance_ready), 32'd1);
        advance = 1'b1;
        cyc;
        advance = 1'b0;
        #1;
        chk("sw_wb_valid", 32'(wb.instr_info.valid), 32'd1);

        do_load("ldb",  EXE_LD_B_OP,  32'h1000_0003, 32'h8011_2233, 32'hFFFF_FF80);
        do_load("ldbu", EXE_LD_BU_OP, 32'h1000_0003, 32'h8011_2233, 32'h0000_0080);
        do_load("ldhu", EXE_LD_HU_OP, 32'h1000_0000, 32'h1234_ABCD, 32'h0000_ABCD);
        do_load("ldw",  EXE_LD_W_OP,  32'h1000_0008, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // LD_H with ready low for three cycles, then parked in HOLD.
        set_ex(EXE_LD_H_OP, 1'b1, 1'b0, 32'h1000_0002, 32'h0, 1'b1, 5'd9, 32'h0, 1'b0);
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) req_ready = 1'b1;
            #1;
            chk("ldh_req_v", 32'(req_valid), 32'd1);
            chk("ldh_req_a", req_addr, 32'h1000_0002);
            chk("ldh_stall", 32'(advance_ready), 32'd0);
            cyc;
        end
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'h8001_1234;
        #1;
        chk("ldh_resp_rdy", 32'(advance_ready), 32'd1);
        cyc;
        resp_valid = 1'b0;
        resp_data  = 32'h0;
        #1;
        chk("ldh_hold", 32'({req_valid, advance_ready}), 32'b01);
`ifdef MEM1_LOAD_FORWARD_EN
        chk("ldh_hold_fwd", fwd.wdata, 32'hFFFF_8001);
        chk("ldh_hold_fwd_v", 32'(fwd.data_valid), 32'd1);
`else
        chk("ldh_hold_fwd_v", 32'(fwd.data_valid), 32'd0);
`endif
        advance = 1'b1;
        cyc;
        advance = 1'b0;
        #1;
        chk("ldh_wb", wb.wdata, 32'hFFFF_8001);

        // Flush in WAIT_RESP; DRAIN swallows the late response.
        set_ex(EXE_LD_W_OP, 1'b1, 1'b0, 32'h1000_0008, 32'h0, 1'b1, 5'd4, 32'h0, 1'b0);
        req_ready = 1'b1;
        #1;
        cyc;
        flush = 1'b1;
        #1;
        chk("fl_wait_rdy", 32'(advance_ready), 32'd0);
        cyc;
        flush = 1'b0;
        set_ex(EXE_ST_W_OP, 1'b0, 1'b1, 32'h1000_000C, 32'h1122_3344, 1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("drain_req", 32'({req_valid, advance_ready}), 32'b00);
        chk("drain_buf", 32'(|wb), 32'd0);
        cyc;
        resp_valid = 1'b1;
        resp_data  = 32'hBAD0_BAD0;
        #1;
        chk("drain_resp", 32'({req_valid, advance_ready}), 32'b00);
        cyc;
        resp_valid = 1'b0;
        #1;
        chk("post_drain_req", 32'({req_valid, advance_ready}), 32'b11);
        chk("post_drain_wd", req_wdata, 32'h1122_3344);
        advance = 1'b1;
        cyc;
        advance = 1'b0;
        #1;
        chk("post_drain_wb", 32'({wb.instr_info.valid, wb.wreg}), 32'b10);

        // Excepting load passes straight through.
        set_ex(EXE_LD_W_OP, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b1, 5'd2, 32'h0, 1'b1);
        #1;
        chk("excp_pass", 32'({req_valid, advance_ready}), 32'b01);
        advance = 1'b1;
        cyc;
        advance = 1'b0;
        #1;
        chk("excp_wb", 32'(wb.instr_info.excp), 32'd1);

        // Byte and half stores; the half store waits for ready, then parks in HOLD.
        set_ex(EXE_ST_B_OP, 1'b0, 1'b1, 32'h1000_0001, 32'h1234_56A5, 1'b0, 5'd0, 32'h0, 1'b0);
        req_ready = 1'b1;
        #1;
        chk("sb_strb", 32'(req_wstrb), 32'h2);
        chk("sb_wdata", req_wdata, 32'hA5A5_A5A5);
        advance = 1'b1;
        cyc;
        advance = 1'b0;
        set_ex(EXE_ST_H_OP, 1'b0, 1'b1, 32'h1000_0002, 32'h1234_BEEF, 1'b0, 5'd0, 32'h0, 1'b0);
        req_ready = 1'b0;
        #1;
        chk("sh_not_ready", 32'({req_valid, advance_ready}), 32'b10);
        req_ready = 1'b1;
        #1;
        chk("sh_strb", 32'(req_wstrb), 32'hC);
        chk("sh_wdata", req_wdata, 32'hBEEF_BEEF);
        cyc;
        #1;
        chk("sh_hold", 32'({req_valid, advance_ready}), 32'b01);
        clear   = 1'b1;
        advance = 1'b1;
        cyc;
        clear   = 1'b0;
        advance = 1'b0;
        #1;
        chk("clear_buf", 32'(|wb), 32'd0);

        // Reset in WAIT_RESP returns the FSM to IDLE.
        set_ex(EXE_LD_W_OP, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b1, 5'd6, 32'h0, 1'b0);
        req_ready = 1'b1;
        #1;
        cyc;
        rst = 1'b0;
        #1;
        chk("rst_wait_out", 32'({req_valid, |fwd}), 32'b00);
        cyc;
        rst = 1'b1;
        #1;
        chk("rst_wait_buf", 32'(|wb), 32'd0);
        chk("rst_wait_idle", 32'({req_valid, advance_ready}), 32'b10);
        cyc;
        resp_valid = 1'b1;
        resp_data  = 32'h0000_CAFE;
        #1;
        chk("rst_reload_rdy", 32'(advance_ready), 32'd1);
        advance = 1'b1;
        cyc;
        advance    = 1'b0;
        resp_valid = 1'b0;
        req_ready  = 1'b0;

        // Non-memory instruction forwards immediately.
        set_ex(8'h01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd12, 32'h0000_55AA, 1'b0);
        #1;
        chk("alu_pass", 32'({req_valid, advance_ready}), 32'b01);
        chk("alu_fwd", 32'({fwd.wreg, fwd.data_valid, fwd.waddr}), 32'b11_01100);
        chk("alu_fwd_data", fwd.wdata, 32'h0000_55AA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem1.md
# mem1

Memory-access stage directly downstream of EX. Consumes the registered `ex_mem_struct` from EX and issues at most one DCache request per instruction: a store, or a load with byte/half/word alignment and sign/zero extension. It stalls the pipeline through `advance_ready` until the access completes, drops in-flight responses on flush, and registers a `mem_wb_struct` for writeback. It also drives the data-forward record for dispatch.

## Interface
- No parameters; widths come from `core_config` (`ADDR_WIDTH` = 32, data 32).
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-low (asserted when 0).
- `flush` in 1: kill current instruction.
- `clear` in 1: bubble output buffer.
- `advance` in 1: pipeline moves this cycle.
- `advance_ready` out 1: this stage can advance.
- `ex_i` in `ex_mem_struct`: EX output buffer, held stable until `advance`.
- `dcache_req_valid_o` out 1: request valid.
- `dcache_req_ready_i` in 1: request accepted.
- `dcache_req_we_o` out 1: 1 = store.
- `dcache_req_addr_o` out 32: `ex_i.mem_addr`.
- `dcache_req_wstrb_o` out 4: byte strobes (0 for loads).
- `dcache_req_wdata_o` out 32: lane-replicated store data.
- `dcache_req_uncached_o` out 1: `ex_i.data_uncache_en`.
- `dcache_resp_valid_i` in 1: load data valid.
- `dcache_resp_data_i` in 32: raw aligned word.
- `data_forward_o` out `data_forward_t`: {wreg, data_valid, waddr, wdata}.
- `mem_o_buffer` out `mem_wb_struct`: registered result.

## Operation
- A memory op is `mem_load | mem_store` with `instr_info.valid=1` and `instr_info.excp=0`. Any other instruction passes through with `advance_ready=1`.
- FSM states: IDLE, WAIT_RESP, HOLD, DRAIN.
- IDLE:
  - `req_valid = memop & !flush`.
  - Accepted store: `advance_ready=1` the same cycle. Next state IDLE if `advance`, else HOLD.
  - Accepted load: go to WAIT_RESP. `advance_ready=0`.
- WAIT_RESP:
  - `resp_valid` and not `flush`: result = extended data, `advance_ready=1`. Next state IDLE if `advance`, else HOLD, with the result latched.
  - `flush` without `resp_valid`: go to DRAIN.
  - `flush` with `resp_valid`: go to IDLE.
- HOLD: no request, `advance_ready=1`, latched result presented. Leave to IDLE on `advance` or `flush`.
- DRAIN: `advance_ready=0`, no request. Return to IDLE on `resp_valid`, which is discarded.
- Store strobes:
  - byte: `4'b1 << addr[1:0]`.
  - half: `addr[1] ? 4'b1100 : 4'b0011`.
  - word: `4'hF`.
- Store wdata:
  - byte: `{4{reg2[7:0]}}`.
  - half: `{2{reg2[15:0]}}`.
  - word: `reg2`.
- Load extraction:
  - Byte lane selected by `addr[1:0]`, half lane by `addr[1]`.
  - `EXE_LD_BU_OP` / `EXE_LD_HU_OP` zero-extend; all other loads sign-extend.
- `mem_o_buffer`:
  - Zero on reset, `flush` or `clear`.
  - Otherwise on `advance` it loads `ex_i` fields, with wdata replaced by load data for loads.

## Timing
- Reset: state=IDLE, `mem_o_buffer`=0, result latch=0, `dcache_req_valid_o`=0, `data_forward_o`=0.
- Store with `ready` already high: zero stall cycles.
- Load: minimum one stall cycle, since the response comes no earlier than the cycle after acceptance.
- `req_valid`, addr, we, wstrb and wdata stay stable while `req_valid & !ready`. Request is never withdrawn except on `flush`.
- Exactly one request per instruction. HOLD never re-requests.
- `advance` while `advance_ready=0` is illegal. The bench asserts this.

## Configuration
- `MEM1_LOAD_FORWARD_EN`:
  - Defined: for a load, `data_forward_o.data_valid=1` with extended data from the `resp_valid` cycle and while in HOLD.
  - Undefined: loads always forward `data_valid=0`; dispatch waits for writeback.
  - Non-load forwarding is identical in both builds.

## Structure
- Add to `core_types`:
  - `mem_wb_struct`.
  - `mem1_state_t` enum (IDLE, WAIT_RESP, HOLD, DRAIN).
  - DCache request/response typedefs (`dcache_req_t`).
- Load aluop codes stay in the existing defines header.
- One sub-module: `load_align`, a combinational lane select and extension taking addr[1:0], b/h flag, signed flag and raw word.

## Test plan
- SW, addr 0x1000_0004, reg2 0xDEADBEEF, ready=1 → same-cycle req, wstrb 0xF, wdata 0xDEADBEEF, `advance_ready=1`, no stall.
- LD_B, addr …03, resp 0x80112233 → wdata 0xFFFFFF80. LD_BU at the same address → 0x00000080. Both after one stall cycle.
- LD_H, addr …02, ready low for 3 cycles, resp 0x8001_1234 → req held stable 4 cycles, wdata 0xFFFF8001.
- Load accepted, flush in WAIT_RESP, resp 2 cycles later → DRAIN absorbs resp, no write, next instruction's request issued only after DRAIN exits.
- Instruction with excp=1 and mem_load → no request, `advance_ready=1`, excp propagated to `mem_o_buffer`.
- `rst=0` mid-WAIT_RESP → next cycle state IDLE, outputs zero. Forward valid on load resp only with `MEM1_LOAD_FORWARD_EN`.
